// File: rtl/debounced_updown_counter_pkg.sv
// debounced_updown_counter_pkg: shared mode constants and width helpers
package debounced_updown_counter_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
  function automatic int sc_width(input int stable);
    return $clog2(stable + 1);
  endfunction
  function automatic int ps_width(input int div);
    return div > 1 ? $clog2(div) : 1;
  endfunction
endpackage

// File: rtl/debounced_updown_counter_if.sv
// debounced_updown_counter_if: button inputs, controls and counter outputs
interface debounced_updown_counter_if #(parameter int WIDTH = 4);
  logic en;
  logic clear;
  logic inc_in;
  logic dec_in;
  logic [WIDTH-1:0] count;
  logic inc_pulse;
  logic dec_pulse;
  logic limit_pulse;
  modport master(output en, clear, inc_in, dec_in, input count, inc_pulse, dec_pulse, limit_pulse);
  modport slave(input en, clear, inc_in, dec_in, output count, inc_pulse, dec_pulse, limit_pulse);
endinterface

// File: rtl/debounced_updown_counter_debounce_channel.sv
// debounce_channel: 2-FF sync, tick-sampled debounce and rising-edge pulse
module debounce_channel import debounced_updown_counter_pkg::*; #(
  parameter int STABLE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic rise,
  output logic pulse
);
  localparam int SW = sc_width(STABLE);
  logic [1:0] sync;
  logic level;
  logic [SW-1:0] cnt;
  logic diff;
  logic full;
  assign diff = sync[1] != level;
  assign full = cnt == SW'(STABLE - 1);
  // rise is combinational so the counter steps on the same edge that sets pulse
  assign rise = tick && diff && full && sync[1];
  // synchronise, count consecutive differing tick samples, accept level on the last one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      level <= 1'b0;
      cnt <= '0;
      pulse <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      pulse <= rise;
      if (tick) begin
        cnt <= (!diff || full) ? '0 : cnt + 1'b1;
        if (diff && full) level <= sync[1];
      end
    end
  end
endmodule

// File: rtl/debounced_updown_counter.sv
// debounced_updown_counter: two debounced buttons driving a wrap/saturate up/down counter
module debounced_updown_counter import debounced_updown_counter_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int DIV = 50000,
  parameter int STABLE = 4,
  parameter int SATURATE = MODE_WRAP
) (
  input logic clk,
  input logic rst,
  debounced_updown_counter_if.slave bus
);
  localparam int PW = ps_width(DIV);
  logic [PW-1:0] ps;
  logic tick;
  logic inc_rise;
  logic dec_rise;
  logic inc_pulse;
  logic dec_pulse;
  logic step;
  logic at_lim;
  logic limit;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] nxt;
  assign tick = ps == PW'(DIV - 1);
  // shared sample-tick prescaler
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ps <= '0;
    else ps <= tick ? '0 : ps + 1'b1;
  end
  debounce_channel #(.STABLE(STABLE)) u_inc (
    .clk(clk), .rst(rst), .tick(tick), .raw(bus.inc_in), .rise(inc_rise), .pulse(inc_pulse)
  );
  debounce_channel #(.STABLE(STABLE)) u_dec (
    .clk(clk), .rst(rst), .tick(tick), .raw(bus.dec_in), .rise(dec_rise), .pulse(dec_pulse)
  );
  // simultaneous presses cancel; at_lim marks a step that would cross a boundary
  always_comb begin
    step = bus.en && (inc_rise ^ dec_rise);
    at_lim = inc_rise ? count == '1 : count == '0;
    nxt = inc_rise ? count + 1'b1 : count - 1'b1;
  end
  // count update with clear > enable priority; saturation holds at the boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      limit <= 1'b0;
    end else begin
      count <= bus.clear ? '0 : (step && !(at_lim && SATURATE == MODE_SAT)) ? nxt : count;
      limit <= !bus.clear && step && at_lim;
    end
  end
  assign bus.count = count;
  assign bus.inc_pulse = inc_pulse;
  assign bus.dec_pulse = dec_pulse;
  assign bus.limit_pulse = limit;
endmodule

// File: tb/tb_debounced_updown_counter.sv
// tb_debounced_updown_counter: scoreboard bench for wrap and saturate variants
module tb_debounced_updown_counter;
  typedef struct {
    bit inc;
    bit dec;
    int c0;
    int l0;
    int c1;
    int l1;
    int t0;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  logic en = 1;
  logic clear = 0;
  logic inc_in = 0;
  logic dec_in = 0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int m0 = 0;
  int m1 = 0;
  exp_t q[$];
  exp_t mx;
  debounced_updown_counter_if #(.WIDTH(4)) b0();
  debounced_updown_counter_if #(.WIDTH(4)) b1();
  assign b0.en = en;
  assign b0.clear = clear;
  assign b0.inc_in = inc_in;
  assign b0.dec_in = dec_in;
  assign b1.en = en;
  assign b1.clear = clear;
  assign b1.inc_in = inc_in;
  assign b1.dec_in = dec_in;
  debounced_updown_counter #(.WIDTH(4), .DIV(4), .STABLE(3), .SATURATE(0)) d0 (.clk(clk), .rst(rst), .bus(b0));
  debounced_updown_counter #(.WIDTH(4), .DIV(4), .STABLE(3), .SATURATE(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic void model(input bit inc, input bit dec, input bit e, input bit c, output int l0, output int l1);
    int d;
    int n;
    l0 = 0;
    l1 = 0;
    if (c) begin
      m0 = 0;
      m1 = 0;
    end else if (e && inc != dec) begin
      d = inc ? 1 : -1;
      n = m0 + d;
      l0 = (n < 0 || n > 15) ? 1 : 0;
      m0 = (n + 16) % 16;
      n = m1 + d;
      l1 = (n < 0 || n > 15) ? 1 : 0;
      m1 = n < 0 ? 0 : n > 15 ? 15 : n;
    end
  endfunction
  task automatic press(input bit inc, input bit dec, input bit bounce, input bit e, input bit c);
    exp_t x;
    @(posedge clk);
    #1;
    en = e;
    clear = c;
    if (bounce) repeat (3) begin
      inc_in = inc;
      dec_in = dec;
      repeat (5) @(posedge clk);
      #1;
      inc_in = 0;
      dec_in = 0;
      repeat (5) @(posedge clk);
      #1;
    end
    inc_in = inc;
    dec_in = dec;
    x.inc = inc;
    x.dec = dec;
    x.t0 = cyc;
    model(inc, dec, e, c, x.l0, x.l1);
    x.c0 = m0;
    x.c1 = m1;
    q.push_back(x);
    repeat (40) @(posedge clk);
    #1;
    if (bounce) repeat (3) begin
      inc_in = 0;
      dec_in = 0;
      repeat (5) @(posedge clk);
      #1;
      inc_in = inc;
      dec_in = dec;
      repeat (5) @(posedge clk);
      #1;
    end
    inc_in = 0;
    dec_in = 0;
    repeat (40) @(posedge clk);
    #1;
    en = 1;
    clear = 0;
  endtask
  task automatic clear_idle();
    @(posedge clk);
    #1;
    clear = 1;
    @(posedge clk);
    #1;
    clear = 0;
    m0 = 0;
    m1 = 0;
  endtask
  task automatic check_zero(input string nm);
    chk({nm, "_count0"}, int'(b0.count), 0);
    chk({nm, "_count1"}, int'(b1.count), 0);
    chk({nm, "_pulses0"}, int'({b0.inc_pulse, b0.dec_pulse, b0.limit_pulse}), 0);
    chk({nm, "_pulses1"}, int'({b1.inc_pulse, b1.dec_pulse, b1.limit_pulse}), 0);
  endtask
  // monitor: every presented pulse is matched against the next expected press
  always @(negedge clk) begin
    if (b0.inc_pulse || b0.dec_pulse || b1.inc_pulse || b1.dec_pulse) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse at cycle %0d inc=%0b dec=%0b", cyc, b0.inc_pulse, b0.dec_pulse);
      end else begin
        mx = q.pop_front();
        chk("inc_pulse0", int'(b0.inc_pulse), int'(mx.inc));
        chk("dec_pulse0", int'(b0.dec_pulse), int'(mx.dec));
        chk("count0", int'(b0.count), mx.c0);
        chk("limit0", int'(b0.limit_pulse), mx.l0);
        chk("inc_pulse1", int'(b1.inc_pulse), int'(mx.inc));
        chk("dec_pulse1", int'(b1.dec_pulse), int'(mx.dec));
        chk("count1", int'(b1.count), mx.c1);
        chk("limit1", int'(b1.limit_pulse), mx.l1);
        if (mx.t0 >= 0) begin
          n_cmp++;
          if (cyc - mx.t0 < 11 || cyc - mx.t0 > 15) begin
            n_bad++;
            $display("FAIL latency got %0d cycles expected 11..15", cyc - mx.t0);
          end
        end
      end
    end else if (b0.limit_pulse || b1.limit_pulse) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stray_limit at cycle %0d got %0b/%0b expected 0", cyc, b0.limit_pulse, b1.limit_pulse);
    end
  end
  initial begin
    exp_t x;
    int k;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 0;
    press(1, 0, 0, 1, 0);
    press(1, 0, 1, 1, 0);
    clear_idle();
    repeat (17) press(1, 0, 0, 1, 0);
    clear_idle();
    press(0, 1, 0, 1, 0);
    press(1, 1, 0, 1, 0);
    press(1, 0, 0, 1, 1);
    press(1, 0, 0, 0, 0);
    press(0, 1, 1, 0, 0);
    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 5);
      press(k < 3 || k == 5, k >= 3, 1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0);
    end
    clear_idle();
    repeat (7) press(1, 0, 0, 1, 0);
    chk("pre_reset_count0", int'(b0.count), 7);
    @(posedge clk);
    #1;
    inc_in = 1;
    repeat (6) @(posedge clk);
    #3;
    rst = 1;
    #1;
    check_zero("async_reset");
    m0 = 0;
    m1 = 0;
    inc_in = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    repeat (60) @(posedge clk);
    #1;
    inc_in = 1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    x.inc = 1;
    x.dec = 0;
    x.t0 = -1;
    model(1, 0, 1, 0, x.l0, x.l1);
    x.c0 = m0;
    x.c1 = m1;
    q.push_back(x);
    repeat (40) @(posedge clk);
    #1;
    inc_in = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("final_count0", int'(b0.count), m0);
    chk("final_count1", int'(b1.count), m1);
    chk("pending_presses", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
